// File: rtl/pipeline_run_ctrl_if.sv
// Request/status bundle between the debug unit and pipeline_run_ctrl.
// master: debug unit / driver side. slave: the run controller.
interface pipeline_run_ctrl_if #(
  parameter int unsigned N_STAGES = 5,
  parameter int unsigned NB_CNT   = 32
);
  logic                start_i;
  logic                step_mode_i;
  logic                step_req_i;
  logic                clear_i;
  logic                stall_i;
  logic                flush_i;
  logic                halt_wb_i;
  logic [N_STAGES-1:0] stage_en_o;
  logic                bubble_o;
  logic                flush_o;
  logic [1:0]          state_o;
  logic                active_o;
  logic                done_o;
  logic [NB_CNT-1:0]   cycle_cnt_o;
  logic [NB_CNT-1:0]   stall_cnt_o;

  modport master (
    output start_i, step_mode_i, step_req_i, clear_i, stall_i, flush_i, halt_wb_i,
    input  stage_en_o, bubble_o, flush_o, state_o, active_o, done_o, cycle_cnt_o, stall_cnt_o
  );

  modport slave (
    input  start_i, step_mode_i, step_req_i, clear_i, stall_i, flush_i, halt_wb_i,
    output stage_en_o, bubble_o, flush_o, state_o, active_o, done_o, cycle_cnt_o, stall_cnt_o
  );
endinterface

// File: rtl/pipeline_run_ctrl.sv
// Run/step controller for the N-stage pipeline: per-stage enables, stall bubbles,
// flush gating, halt-to-done sequencing and saturating debug counters.
// Optional: define PIPE_RUN_CTRL_STALL_CNT_EN to build the stall counter;
// otherwise stall_cnt_o is tied to 0.
module pipeline_run_ctrl #(
  parameter int unsigned N_STAGES    = 5,
  parameter int unsigned STALL_DEPTH = 2,
  parameter int unsigned NB_CNT      = 32
) (
  input logic                clock_i,
  input logic                reset_i,
  pipeline_run_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStepWait = 2'd2,
    StDone     = 2'd3
  } state_e;

  localparam logic [NB_CNT-1:0] CntOne = {{(NB_CNT-1){1'b0}}, 1'b1};

  state_e              state_q, state_d;
  logic                adv;
  logic                cnt_clr;
  logic [N_STAGES-1:0] stage_en;
  logic                bubble;
  logic                flush;
  logic [NB_CNT-1:0]   cycle_cnt_q, cycle_cnt_d;
  logic [NB_CNT-1:0]   stall_cnt;

  // Next-state decode and advance qualifier.
  always_comb begin
    state_d = state_q;
    adv     = 1'b0;
    cnt_clr = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.start_i) begin
          cnt_clr = 1'b1;
          state_d = bus.step_mode_i ? StStepWait : StRun;
        end
      end
      StRun: begin
        adv = 1'b1;
        if (bus.halt_wb_i) state_d = StDone;
      end
      StStepWait: begin
        adv = bus.step_req_i;
        // A halt seen while frozen has already retired, so no step is needed.
        if (bus.halt_wb_i) state_d = StDone;
      end
      StDone: begin
        if (bus.clear_i) state_d = StIdle;
      end
    endcase
  end

  // Per-stage enables; a stall freezes the front STALL_DEPTH groups and inserts a bubble.
  always_comb begin
    stage_en = '0;
    bubble   = 1'b0;
    flush    = 1'b0;
    if (adv) begin
      for (int unsigned i = 0; i < N_STAGES; i++) begin
        stage_en[i] = ~(bus.stall_i & (i < STALL_DEPTH));
      end
      bubble = bus.stall_i;
      // Stall wins: a branch resolved on stale operands must not flush.
      flush  = bus.flush_i & ~bus.stall_i;
    end
  end

  // Saturating cycle counter next value.
  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    if (cnt_clr) begin
      cycle_cnt_d = '0;
    end else if (adv && (cycle_cnt_q != {NB_CNT{1'b1}})) begin
      cycle_cnt_d = cycle_cnt_q + CntOne;
    end
  end

  // State and cycle counter registers.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      state_q     <= StIdle;
      cycle_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
    end
  end

`ifdef PIPE_RUN_CTRL_STALL_CNT_EN
  logic [NB_CNT-1:0] stall_cnt_q, stall_cnt_d;

  // Saturating stall counter next value.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cnt_clr) begin
      stall_cnt_d = '0;
    end else if (adv && bus.stall_i && (stall_cnt_q != {NB_CNT{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CntOne;
    end
  end

  // Stall counter register.
  always_ff @(posedge clock_i) begin
    if (!reset_i) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

  assign bus.stage_en_o  = stage_en;
  assign bus.bubble_o    = bubble;
  assign bus.flush_o     = flush;
  assign bus.active_o    = adv;
  assign bus.state_o     = state_q;
  assign bus.done_o      = (state_q == StDone);
  assign bus.cycle_cnt_o = cycle_cnt_q;
  assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: doc/pipeline_run_ctrl.md
# pipeline_run_ctrl

Parametrised run/step controller for the N-stage MIPS pipeline. It replaces the flat `en_pipeline` wire and the fixed two-stage hazard freeze with per-stage enables. It supports:
- continuous and single-step execution;
- configurable stall depth;
- flush on taken branch/jump;
- halt-to-done sequencing;
- cycle and stall counters for the debug unit.

It sits between the debug/UART unit and the pipeline top. The hazard unit, decode and write-back halt outputs feed it.

## Interface
Parameters:
- `N_STAGES`, 5, number of pipeline register groups (index 0 = PC, 1 = IF/ID, … N_STAGES-1 = MEM/WB)
- `STALL_DEPTH`, 2, number of front groups frozen on stall (1..N_STAGES-1)
- `NB_CNT`, 32, width of counters

Ports:
- `clock_i` in 1 — system clock
- `reset_i` in 1 — synchronous, active-low reset
- `start_i` in 1 — begin execution (level, sampled in IDLE)
- `step_mode_i` in 1 — 0 = continuous, 1 = single-step (sampled with `start_i`)
- `step_req_i` in 1 — one-cycle pulse requesting one step
- `clear_i` in 1 — leave DONE, return to IDLE
- `stall_i` in 1 — load-use/halt stall from hazard unit
- `flush_i` in 1 — taken branch/jump resolved in decode
- `halt_wb_i` in 1 — halt instruction present at write-back
- `stage_en_o` out N_STAGES — per-group register enable
- `bubble_o` out 1 — load NOP controls into DEC/EX
- `flush_o` out 1 — clear IF/ID instruction
- `state_o` out 2 — 0 IDLE, 1 RUN, 2 STEP_WAIT, 3 DONE
- `active_o` out 1 — pipeline advances this cycle
- `done_o` out 1 — state is DONE
- `cycle_cnt_o` out NB_CNT — active cycles since start
- `stall_cnt_o` out NB_CNT — active cycles with stall asserted

## Operation
- Internal signal `adv` = (state==RUN) | (state==STEP_WAIT & `step_req_i`). `active_o` = `adv`.
- IDLE:
  - If `start_i`=1, go to RUN when `step_mode_i`=0, else to STEP_WAIT.
  - Counters clear to 0 on this transition.
- RUN:
  - `adv`=1 every cycle.
  - `halt_wb_i`=1 → DONE.
- STEP_WAIT:
  - Each `step_req_i` pulse produces exactly one `adv` cycle.
  - `halt_wb_i`=1 on an advancing cycle → DONE.
  - `halt_wb_i`=1 with no step → DONE. The pipeline is frozen, so the halt is already retired.
- DONE:
  - `adv`=0; `step_req_i` and `start_i` are ignored.
  - `clear_i`=1 → IDLE.
- Stage enables, when `adv`=1:
  - `stall_i`=0: all bits of `stage_en_o` are 1.
  - `stall_i`=1: bits [STALL_DEPTH-1:0] are 0, the rest are 1, and `bubble_o`=1.
  - When `adv`=0, all outputs are 0.
- `flush_o` = `adv` & `flush_i` & ~`stall_i`. Stall has priority: a branch resolved against stale operands must not flush.
- Counters:
  - `cycle_cnt_o` increments on each `adv` cycle.
  - `stall_cnt_o` increments on `adv` & `stall_i`.
  - Both saturate at 2^NB_CNT-1.
  - Both hold in DONE, for debug readout.

## Timing
- Reset (`reset_i`=0 at a rising edge): state IDLE, counters 0. All outputs are 0 the following cycle.
- `reset_i` asserted mid-run aborts immediately; there is no drain.
- Output timing:
  - `state_o`, `done_o` and the counters are registered.
  - `stage_en_o`, `bubble_o`, `flush_o` and `active_o` are combinational from state and inputs, with no added latency.
- `start_i` sampled at edge k: the first `adv` cycle is k+1 (RUN).
- `halt_wb_i` high in cycle k with `adv`=1: that cycle still advances and is counted. `done_o`=1 from cycle k+1.
- `step_req_i` held high for n cycles in STEP_WAIT gives n steps. It is level-sensitive per cycle; the debug unit owns the pulse shaping.
- If `clear_i` and `start_i` are both high in DONE, only `clear_i` acts; `start_i` is taken on the next IDLE cycle.

## Configuration
- `PIPE_RUN_CTRL_STALL_CNT_EN`:
  - Defined: the stall counter is built as described.
  - Undefined: no stall counter register; `stall_cnt_o` is tied to 0.
  - All other behaviour is identical in both cases.

## Test plan
- Reset, then `start_i`=1 with `step_mode_i`=0, then `halt_wb_i` at the 10th RUN cycle → `stage_en_o`=5'b11111 for 10 cycles, `cycle_cnt_o`=10, then `done_o`=1 and `stage_en_o`=0.
- Step mode with 3 `step_req_i` pulses spaced 4 cycles apart → exactly 3 cycles with `active_o`=1, `cycle_cnt_o`=3, state stays 2.
- RUN with `stall_i`=1 for 2 cycles → `stage_en_o`=5'b11100 and `bubble_o`=1 in both; `stall_cnt_o`=2 (0 when the macro is undefined).
- `flush_i`=1 with `stall_i`=0 → `flush_o`=1. `flush_i`=1 with `stall_i`=1 → `flush_o`=0.
- `NB_CNT`=4, RUN for 20 cycles → `cycle_cnt_o` saturates at 15.
- `reset_i`=0 during RUN at cycle 6 → IDLE, counters 0, `stage_en_o`=0 next cycle. DONE with `clear_i`=1 → IDLE, counters retained until the next start.
